// File: rtl/dbus_arbiter.sv
// Two-master data-bus arbiter: combinational round-robin grant, optional bus lock with
// timeout, one-cycle read-response tagging and a saturating conflict counter.
module dbus_arbiter #(
  parameter int unsigned LOCK_MAX = 16,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_en,
  input  logic                  m1_en,
  input  logic                  m0_rdwr,
  input  logic                  m1_rdwr,
  input  logic [3:0]            m0_mask,
  input  logic [3:0]            m1_mask,
  input  logic [3:0][7:0]       m0_wr_data,
  input  logic [3:0][7:0]       m1_wr_data,
  input  logic [31:0]           m0_addr,
  input  logic [31:0]           m1_addr,
  input  logic                  m0_lock,
  input  logic                  m1_lock,
  output logic                  m0_gnt,
  output logic                  m1_gnt,
  output logic                  m0_rvalid,
  output logic                  m1_rvalid,
  output logic [31:0]           m_rd_data,
  output logic                  s_en,
  output logic                  s_rdwr,
  output logic [3:0]            s_mask,
  output logic [3:0][7:0]       s_wr_data,
  output logic [31:0]           s_addr,
  input  logic [31:0]           s_rd_data,
  output logic                  lock_timeout,
  output logic [CNT_W-1:0]      conflict_cnt
);

  localparam logic [7:0] LockCntMax = 8'(LOCK_MAX - 1);

  typedef enum logic [1:0] {StIdle, StLock0, StLock1} state_e;

  state_e           r_state, w_state_nxt;
  logic             r_last_gnt, w_last_gnt_nxt;
  logic [7:0]       r_lock_cnt, w_lock_cnt_nxt;
  logic             r_lock_timeout, w_lock_timeout_nxt;
  logic             r_rsp_pend, r_rsp_id;
  logic [CNT_W-1:0] r_conflict_cnt;

  logic w_gnt0, w_gnt1, w_accept, w_sel, w_sel_lock, w_own, w_own_lock;

  // Grants are gated by rst_n so nothing is accepted while reset is held.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    unique case (r_state)
      StLock0: w_gnt0 = m0_en;
      StLock1: w_gnt1 = m1_en;
      default: begin
        if (m0_en && m1_en) begin
          w_gnt0 = r_last_gnt;
          w_gnt1 = ~r_last_gnt;
        end else begin
          w_gnt0 = m0_en;
          w_gnt1 = m1_en;
        end
      end
    endcase
    if (!rst_n) begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
    end
  end

  assign w_accept   = w_gnt0 | w_gnt1;
  assign w_sel      = w_gnt1;
  assign w_sel_lock = w_sel ? m1_lock : m0_lock;
  assign w_own      = (r_state == StLock1);
  assign w_own_lock = w_own ? m1_lock : m0_lock;

  assign m0_gnt    = w_gnt0;
  assign m1_gnt    = w_gnt1;
  assign s_en      = w_accept;
  assign s_rdwr    = w_sel ? m1_rdwr    : m0_rdwr;
  assign s_mask    = w_sel ? m1_mask    : m0_mask;
  assign s_wr_data = w_sel ? m1_wr_data : m0_wr_data;
  assign s_addr    = w_sel ? m1_addr    : m0_addr;

  assign m0_rvalid    = r_rsp_pend & ~r_rsp_id;
  assign m1_rvalid    = r_rsp_pend & r_rsp_id;
  assign m_rd_data    = s_rd_data;
  assign lock_timeout = r_lock_timeout;
  assign conflict_cnt = r_conflict_cnt;

  always_comb begin
    w_state_nxt        = r_state;
    w_lock_cnt_nxt     = r_lock_cnt;
    w_lock_timeout_nxt = 1'b0;
    w_last_gnt_nxt     = w_accept ? w_sel : r_last_gnt;
    unique case (r_state)
      StLock0, StLock1: begin
        if (r_lock_cnt == LockCntMax) begin
          // Forced release hands the next conflict to the other master.
          w_state_nxt        = StIdle;
          w_lock_cnt_nxt     = 8'd0;
          w_last_gnt_nxt     = w_own;
          w_lock_timeout_nxt = 1'b1;
        end else if (!w_own_lock) begin
          w_state_nxt    = StIdle;
          w_lock_cnt_nxt = 8'd0;
        end else begin
          w_lock_cnt_nxt = r_lock_cnt + 8'd1;
        end
      end
      default: begin
        if (w_accept && w_sel_lock) begin
          w_state_nxt    = w_sel ? StLock1 : StLock0;
          w_lock_cnt_nxt = 8'd0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= StIdle;
      r_last_gnt     <= 1'b1;
      r_lock_cnt     <= 8'd0;
      r_lock_timeout <= 1'b0;
      r_rsp_pend     <= 1'b0;
      r_rsp_id       <= 1'b0;
      r_conflict_cnt <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_last_gnt     <= w_last_gnt_nxt;
      r_lock_cnt     <= w_lock_cnt_nxt;
      r_lock_timeout <= w_lock_timeout_nxt;
      r_rsp_pend     <= w_accept & ~s_rdwr;
      r_rsp_id       <= w_sel;
      if (m0_en && m1_en && (r_conflict_cnt != '1)) begin
        r_conflict_cnt <= r_conflict_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed and randomized bench for dbus_arbiter; every cycle is compared against a
// transaction-level model of ownership, round-robin history and pending read responses.
module tb_dbus_arbiter;

  localparam int unsigned LM = 4;
  localparam int unsigned CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic m0_en = 0, m1_en = 0, m0_rdwr = 0, m1_rdwr = 0, m0_lock = 0, m1_lock = 0;
  logic [3:0] m0_mask = 0, m1_mask = 0;
  logic [3:0][7:0] m0_wr_data = 0, m1_wr_data = 0;
  logic [31:0] m0_addr = 0, m1_addr = 0, s_rd_data = 0;
  logic m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, s_en, s_rdwr, lock_timeout;
  logic [31:0] m_rd_data, s_addr;
  logic [3:0] s_mask;
  logic [3:0][7:0] s_wr_data;
  logic [CW-1:0] conflict_cnt;

  always #5 clk = ~clk;

  dbus_arbiter #(.LOCK_MAX(LM), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_en(m0_en), .m1_en(m1_en), .m0_rdwr(m0_rdwr), .m1_rdwr(m1_rdwr),
    .m0_mask(m0_mask), .m1_mask(m1_mask), .m0_wr_data(m0_wr_data), .m1_wr_data(m1_wr_data),
    .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_lock(m0_lock), .m1_lock(m1_lock),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m_rd_data(m_rd_data), .s_en(s_en), .s_rdwr(s_rdwr), .s_mask(s_mask),
    .s_wr_data(s_wr_data), .s_addr(s_addr), .s_rd_data(s_rd_data),
    .lock_timeout(lock_timeout), .conflict_cnt(conflict_cnt)
  );

  int total = 0, bad = 0;

  // Model: owner is the locking master (-1 = none), age is cycles spent locked,
  // prev is the last master served, rsp_q holds reads whose data is due this cycle.
  int owner, age, prev, conf;
  int rsp_q[$];
  bit exp_to, e_g0, e_g1;
  int n_g0, n_g1, n_to;
  bit to_g1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    owner = -1; age = 0; prev = 1; conf = 0; exp_to = 0;
    rsp_q.delete();
  endtask

  task automatic drive(input bit en0, input bit rw0, input bit lk0,
                       input bit en1, input bit rw1, input bit lk1);
    m0_en = en0; m0_rdwr = rw0; m0_lock = lk0;
    m1_en = en1; m1_rdwr = rw1; m1_lock = lk1;
    m0_mask = 4'($urandom); m1_mask = 4'($urandom);
    m0_wr_data = $urandom; m1_wr_data = $urandom;
    m0_addr = $urandom; m1_addr = $urandom; s_rd_data = $urandom;
  endtask

  task automatic predict();
    e_g0 = 0; e_g1 = 0;
    if (owner == 0) e_g0 = m0_en;
    else if (owner == 1) e_g1 = m1_en;
    else if (m0_en && m1_en) begin
      if (prev == 1) e_g0 = 1; else e_g1 = 1;
    end else begin
      e_g0 = m0_en; e_g1 = m1_en;
    end
  endtask

  task automatic compare();
    bit rv0, rv1;
    rv0 = (rsp_q.size() > 0) && (rsp_q[0] == 0);
    rv1 = (rsp_q.size() > 0) && (rsp_q[0] == 1);
    check("m0_gnt", 32'(m0_gnt), 32'(e_g0));
    check("m1_gnt", 32'(m1_gnt), 32'(e_g1));
    check("s_en", 32'(s_en), 32'(e_g0 | e_g1));
    if (e_g0 | e_g1) begin
      check("s_rdwr", 32'(s_rdwr), 32'(e_g1 ? m1_rdwr : m0_rdwr));
      check("s_mask", 32'(s_mask), 32'(e_g1 ? m1_mask : m0_mask));
      check("s_wr_data", s_wr_data, e_g1 ? m1_wr_data : m0_wr_data);
      check("s_addr", s_addr, e_g1 ? m1_addr : m0_addr);
    end
    check("m0_rvalid", 32'(m0_rvalid), 32'(rv0));
    check("m1_rvalid", 32'(m1_rvalid), 32'(rv1));
    check("m_rd_data", m_rd_data, s_rd_data);
    check("lock_timeout", 32'(lock_timeout), 32'(exp_to));
    check("conflict_cnt", 32'(conflict_cnt), 32'(conf));
  endtask

  task automatic advance();
    int w;
    bit acc, wr, lk;
    w = e_g1 ? 1 : 0;
    acc = e_g0 | e_g1;
    wr = w ? m1_rdwr : m0_rdwr;
    lk = w ? m1_lock : m0_lock;
    if (m0_en && m1_en && conf < CMAX) conf++;
    rsp_q.delete();
    if (acc && !wr) rsp_q.push_back(w);
    exp_to = 0;
    if (acc) prev = w;
    if (owner < 0) begin
      if (acc && lk) begin owner = w; age = 0; end
    end else begin
      age++;
      if (age == int'(LM)) begin prev = owner; owner = -1; exp_to = 1; end
      else if (!(owner == 1 ? m1_lock : m0_lock)) owner = -1;
    end
  endtask

  task automatic step();
    #4;
    predict();
    compare();
    n_g0 += int'(m0_gnt); n_g1 += int'(m1_gnt); n_to += int'(lock_timeout);
    if (lock_timeout && m1_gnt) to_g1 = 1;
    @(posedge clk);
    advance();
    #1;
  endtask

  task automatic check_reset_outputs();
    check("rst_m0_gnt", 32'(m0_gnt), 0);
    check("rst_m1_gnt", 32'(m1_gnt), 0);
    check("rst_s_en", 32'(s_en), 0);
    check("rst_m0_rvalid", 32'(m0_rvalid), 0);
    check("rst_m1_rvalid", 32'(m1_rvalid), 0);
    check("rst_timeout", 32'(lock_timeout), 0);
    check("rst_conflict", 32'(conflict_cnt), 0);
  endtask

  initial begin
    model_reset();
    n_g0 = 0; n_g1 = 0; n_to = 0; to_g1 = 0;
    // Requests held high during reset must not be granted.
    drive(1, 0, 0, 1, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;

    // Simultaneous reads: m0 first, then m1; responses one cycle later.
    drive(1, 0, 0, 1, 0, 0); step();
    drive(0, 0, 0, 1, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0); step();
    check("first_conflict_cnt", 32'(conflict_cnt), 1);

    // Continuous contention alternates grants.
    n_g0 = 0; n_g1 = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 0, 1, 0, 0); step();
    end
    check("rr_m0_count", 32'(n_g0), 4);
    check("rr_m1_count", 32'(n_g1), 4);

    // m1 locks with a write; m0 is locked out until m1 drops the lock.
    drive(0, 0, 0, 1, 1, 1); step();
    n_g0 = 0;
    drive(1, 1, 0, 0, 0, 1); step();
    drive(1, 1, 0, 0, 0, 1); step();
    drive(1, 1, 0, 0, 0, 0); step();
    check("lock_blocks_m0", 32'(n_g0), 0);
    drive(1, 1, 0, 0, 0, 0); step();
    check("m0_after_unlock", 32'(n_g0), 1);

    // m0 holds the lock indefinitely; forced release favours m1.
    n_to = 0; to_g1 = 0;
    drive(1, 1, 1, 0, 0, 0); step();
    for (int i = 0; i < 6; i++) begin
      drive(1, 1, 1, 1, 1, 0); step();
    end
    check("timeout_pulses", 32'(n_to), 1);
    check("m1_on_release", 32'(to_g1), 1);
    drive(0, 0, 0, 0, 0, 0); step();

    // Asynchronous reset mid-lock with a read outstanding.
    drive(1, 0, 1, 0, 0, 0); step();
    drive(1, 0, 1, 1, 0, 0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1, 0, 0, 1, 0, 0); step();
    check("m0_wins_after_rst", 32'(prev), 0);
    drive(0, 0, 0, 1, 0, 0); step();

    // Randomized traffic with occasional locks.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0),
            1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0));
      step();
    end

    // Counter must stay saturated under further contention.
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 1, 1, 0); step();
    end
    check("conflict_saturated", 32'(conflict_cnt), CMAX);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
